// File: rtl/priority_arbiter4.sv
// ----------------------------------------------------------------------------
// priority_arbiter4
//
// Four-requester arbiter. The key for each requester is {request, age,
// priority}, and the largest key wins. Ties are broken in a two-level tree:
// pair (0,1) favours 1, pair (2,3) favours 3, and the final stage favours the
// (2,3) winner. An owner keeps its grant while it requests. After HOLD_MAX
// consecutive grant cycles with someone else waiting, the grant is forcibly
// revoked, and one idle cycle follows before the next arbitration.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   I_Req      per-requester request level (bit i = requester i)
//   I_Pri0..3  static priority of each requester
//   O_Grant    registered one-hot grant (zero when no owner)
//   O_Owner    registered owner index, valid while O_Busy=1
//   O_Busy     registered, OR of O_Grant
//   O_Revoke   registered one-cycle pulse on forced revocation
// ----------------------------------------------------------------------------
module priority_arbiter4 #(
    parameter int unsigned WIDTH_PRI = 4,
    parameter int unsigned WIDTH_AGE = 3,
    parameter int unsigned HOLD_MAX  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           I_Req,
    input  logic [WIDTH_PRI-1:0] I_Pri0,
    input  logic [WIDTH_PRI-1:0] I_Pri1,
    input  logic [WIDTH_PRI-1:0] I_Pri2,
    input  logic [WIDTH_PRI-1:0] I_Pri3,
    output logic [3:0]           O_Grant,
    output logic [1:0]           O_Owner,
    output logic                 O_Busy,
    output logic                 O_Revoke
);

    localparam int unsigned KeyW  = 1 + WIDTH_AGE + WIDTH_PRI;
    localparam int unsigned HoldW = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HoldW-1:0]     HoldLast = HoldW'(HOLD_MAX - 1);
    localparam logic [WIDTH_AGE-1:0] AgeMax   = '1;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StRevoke
    } state_e;

    state_e               r_state, w_state_d;
    logic [3:0]           r_grant, w_grant_d;
    logic [1:0]           r_owner, w_owner_d;
    logic                 r_busy;
    logic                 r_revoke, w_revoke_d;
    logic [HoldW-1:0]     r_hold, w_hold_d;
    logic [WIDTH_AGE-1:0] r_age [4];
    logic [WIDTH_AGE-1:0] w_age_d [4];

    logic [WIDTH_PRI-1:0] w_pri [4];
    logic [KeyW-1:0]      w_key [4];
    logic [1:0]           w_win01, w_win23, w_winner;
    logic [KeyW-1:0]      w_key01, w_key23;
    logic                 w_others;

    assign w_pri[0] = I_Pri0;
    assign w_pri[1] = I_Pri1;
    assign w_pri[2] = I_Pri2;
    assign w_pri[3] = I_Pri3;

    // The request bit is the key MSB, so any requester outranks every idle one.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_key[i] = {I_Req[i], r_age[i], w_pri[i]};
        end
    end

    // Tie-break tree: >= on the higher index makes ties favour 1, 3 and the (2,3) side.
    always_comb begin
        w_win01  = (w_key[1] >= w_key[0]) ? 2'd1 : 2'd0;
        w_key01  = (w_key[1] >= w_key[0]) ? w_key[1] : w_key[0];
        w_win23  = (w_key[3] >= w_key[2]) ? 2'd3 : 2'd2;
        w_key23  = (w_key[3] >= w_key[2]) ? w_key[3] : w_key[2];
        w_winner = (w_key23 >= w_key01) ? w_win23 : w_win01;
    end

    assign w_others = |(I_Req & ~r_grant);

    always_comb begin
        w_state_d  = r_state;
        w_grant_d  = r_grant;
        w_owner_d  = r_owner;
        w_hold_d   = r_hold;
        w_revoke_d = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_grant_d = 4'b0000;
                if (|I_Req) begin
                    w_grant_d = 4'b0001 << w_winner;
                    w_owner_d = w_winner;
                    w_hold_d  = '0;
                    w_state_d = StGrant;
                end
            end
            StGrant: begin
                // A drop wins over a simultaneous timeout: no revoke pulse.
                if (!I_Req[r_owner]) begin
                    w_grant_d = 4'b0000;
                    w_state_d = StIdle;
                end else if (r_hold == HoldLast) begin
                    // Saturated: the grant is kept until somebody else asks.
                    if (w_others) begin
                        w_grant_d  = 4'b0000;
                        w_revoke_d = 1'b1;
                        w_state_d  = StRevoke;
                    end
                end else begin
                    w_hold_d = r_hold + 1'b1;
                end
            end
            StRevoke: begin
                w_grant_d = 4'b0000;
                w_state_d = StIdle;
            end
            default: begin
                w_grant_d = 4'b0000;
                w_state_d = StIdle;
            end
        endcase
    end

    // Ages clear while idle or owning (current or incoming), otherwise saturate upward.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_age_d[i] = r_age[i];
            if (!I_Req[i] || r_grant[i] || w_grant_d[i]) begin
                w_age_d[i] = '0;
            end else if (r_age[i] != AgeMax) begin
                w_age_d[i] = r_age[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_grant  <= 4'b0000;
            r_owner  <= 2'd0;
            r_busy   <= 1'b0;
            r_revoke <= 1'b0;
            r_hold   <= '0;
            for (int i = 0; i < 4; i++) begin
                r_age[i] <= '0;
            end
        end else begin
            r_state  <= w_state_d;
            r_grant  <= w_grant_d;
            r_owner  <= w_owner_d;
            r_busy   <= |w_grant_d;
            r_revoke <= w_revoke_d;
            r_hold   <= w_hold_d;
            for (int i = 0; i < 4; i++) begin
                r_age[i] <= w_age_d[i];
            end
        end
    end

    assign O_Grant  = r_grant;
    assign O_Owner  = r_owner;
    assign O_Busy   = r_busy;
    assign O_Revoke = r_revoke;

endmodule

// File: tb/tb_priority_arbiter4.sv
// ----------------------------------------------------------------------------
// tb_priority_arbiter4
//
// Directed bench for priority_arbiter4 with hand-computed expectations.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_priority_arbiter4;

    logic       clk;
    logic       rst_n;
    logic [3:0] I_Req;
    logic [3:0] I_Pri0, I_Pri1, I_Pri2, I_Pri3;
    logic [3:0] O_Grant;
    logic [1:0] O_Owner;
    logic       O_Busy;
    logic       O_Revoke;

    int n_checks = 0;
    int n_errors = 0;

    priority_arbiter4 #(
        .WIDTH_PRI (4),
        .WIDTH_AGE (3),
        .HOLD_MAX  (16)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .I_Req    (I_Req),
        .I_Pri0   (I_Pri0),
        .I_Pri1   (I_Pri1),
        .I_Pri2   (I_Pri2),
        .I_Pri3   (I_Pri3),
        .O_Grant  (O_Grant),
        .O_Owner  (O_Owner),
        .O_Busy   (O_Busy),
        .O_Revoke (O_Revoke)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_pri(input logic [3:0] p0, input logic [3:0] p1,
                           input logic [3:0] p2, input logic [3:0] p3);
        I_Pri0 = p0;
        I_Pri1 = p1;
        I_Pri2 = p2;
        I_Pri3 = p3;
    endtask

    // Present a request from IDLE with all ages zero, check the grant one
    // cycle later, then release everything and let the arbiter return to IDLE.
    task automatic run_vec(input string tag, input logic [3:0] req,
                           input logic [3:0] p0, input logic [3:0] p1,
                           input logic [3:0] p2, input logic [3:0] p3,
                           input logic [3:0] exp_grant, input logic [1:0] exp_owner);
        set_pri(p0, p1, p2, p3);
        I_Req = req;
        tick();
        check_eq({tag, "_grant"}, 32'(O_Grant), 32'(exp_grant));
        check_eq({tag, "_owner"}, 32'(O_Owner), 32'(exp_owner));
        check_eq({tag, "_busy"}, 32'(O_Busy), 32'd1);
        I_Req = 4'b0000;
        tick();
        check_eq({tag, "_drop"}, 32'(O_Grant), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        I_Req = 4'b0000;
        set_pri(4'd0, 4'd0, 4'd0, 4'd0);
        repeat (3) tick();
        check_eq("rst_grant", 32'(O_Grant), 32'd0);
        check_eq("rst_owner", 32'(O_Owner), 32'd0);
        check_eq("rst_busy", 32'(O_Busy), 32'd0);
        check_eq("rst_revoke", 32'(O_Revoke), 32'd0);

        rst_n = 1'b1;
        tick();
        check_eq("idle_no_req", 32'(O_Grant), 32'd0);

        // Arbitration from IDLE.
        run_vec("single_r2", 4'b0100, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0100, 2'd2);
        run_vec("tie_1v3", 4'b1111, 4'd5, 4'd5, 4'd3, 4'd5, 4'b1000, 2'd3);
        run_vec("tie_0v1", 4'b0011, 4'd7, 4'd7, 4'd0, 4'd0, 4'b0010, 2'd1);
        run_vec("tie_0v2", 4'b0101, 4'd4, 4'd0, 4'd4, 4'd0, 4'b0100, 2'd2);
        run_vec("pri_0", 4'b0011, 4'd9, 4'd2, 4'd0, 4'd0, 4'b0001, 2'd0);
        run_vec("pri_2", 4'b1110, 4'd15, 4'd1, 4'd15, 4'd14, 4'b0100, 2'd2);
        run_vec("noreq_ign", 4'b0001, 4'd0, 4'd15, 4'd15, 4'd15, 4'b0001, 2'd0);

        // Owner 3 drops while requester 1 waits.
        set_pri(4'd0, 4'd0, 4'd0, 4'd0);
        I_Req = 4'b1010;
        tick();
        check_eq("drop_own3", 32'(O_Grant), 32'b1000);
        I_Req = 4'b0010;
        tick();
        check_eq("drop_gap", 32'(O_Grant), 32'b0000);
        check_eq("drop_norev", 32'(O_Revoke), 32'd0);
        tick();
        check_eq("drop_next", 32'(O_Grant), 32'b0010);
        check_eq("drop_next_own", 32'(O_Owner), 32'd1);
        I_Req = 4'b0000;
        tick();
        tick();

        // Requester 0 holds for 16 cycles while requester 1 waits, then is revoked.
        I_Req = 4'b0001;
        tick();
        check_eq("hold_c1", 32'({O_Revoke, O_Grant}), 32'b0_0001);
        I_Req = 4'b0011;
        for (int k = 2; k <= 16; k++) begin
            tick();
            check_eq("hold_cyc", 32'({O_Revoke, O_Grant}), 32'b0_0001);
        end
        tick();
        check_eq("rev_pulse", 32'(O_Revoke), 32'd1);
        check_eq("rev_grant", 32'(O_Grant), 32'd0);
        check_eq("rev_busy", 32'(O_Busy), 32'd0);
        tick();
        check_eq("rev_idle_gnt", 32'(O_Grant), 32'd0);
        check_eq("rev_idle_rev", 32'(O_Revoke), 32'd0);
        tick();
        check_eq("rev_aged_gnt", 32'(O_Grant), 32'b0010);
        check_eq("rev_aged_own", 32'(O_Owner), 32'd1);
        I_Req = 4'b0000;
        tick();
        tick();

        // Sole requester is never revoked; a late competitor triggers revoke at once.
        I_Req = 4'b0001;
        for (int k = 0; k < 40; k++) begin
            tick();
            check_eq("sole_hold", 32'({O_Revoke, O_Grant}), 32'b0_0001);
        end
        I_Req = 4'b0101;
        tick();
        check_eq("sat_revoke", 32'({O_Revoke, O_Grant}), 32'b1_0000);
        tick();
        check_eq("sat_idle", 32'({O_Revoke, O_Grant}), 32'b0_0000);
        tick();
        check_eq("sat_next", 32'(O_Grant), 32'b0100);
        I_Req = 4'b0000;
        tick();
        tick();

        // Asynchronous reset in the middle of a grant.
        I_Req = 4'b0001;
        tick();
        check_eq("prerst_grant", 32'(O_Grant), 32'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_grant", 32'(O_Grant), 32'd0);
        check_eq("arst_busy", 32'(O_Busy), 32'd0);
        check_eq("arst_revoke", 32'(O_Revoke), 32'd0);
        check_eq("arst_owner", 32'(O_Owner), 32'd0);
        tick();
        rst_n = 1'b1;
        check_eq("postrst_gnt0", 32'(O_Grant), 32'd0);
        tick();
        check_eq("postrst_grant", 32'(O_Grant), 32'b0001);
        check_eq("postrst_rev", 32'(O_Revoke), 32'd0);
        I_Req = 4'b0000;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/priority_arbiter4.md
PRIORITY_ARBITER4 -- requirements
Module: priority_arbiter4

Interface
REQ-001 Parameter WIDTH_PRI, default 4, width of each requester priority field.
REQ-002 Parameter WIDTH_AGE, default 3, width of each requester aging counter (saturates at 2^WIDTH_AGE-1).
REQ-003 Parameter HOLD_MAX, default 16, maximum consecutive grant cycles before forced revocation when others wait.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 I_Req  input  4  per-requester request level; bit i = requester i.
REQ-007 I_Pri0..I_Pri3  input  WIDTH_PRI each  static priority of requester i, sampled every arbitration cycle.
REQ-008 O_Grant  output  4  one-hot grant, registered; all-zero when no owner.
REQ-009 O_Owner  output  2  index of current owner, registered; valid only when O_Busy=1.
REQ-010 O_Busy  output  1  registered; 1 while any grant bit is set.
REQ-011 O_Revoke  output  1  registered one-cycle pulse marking forced revocation of the previous owner.

Function
REQ-012 Arbitration key for requester i SHALL be the unsigned concatenation {I_Req[i], Age[i], I_Pri_i}; largest key wins.
REQ-013 Ties SHALL resolve two-level: pair (0,1) favours 1, pair (2,3) favours 3, final stage favours the (2,3) winner.
REQ-014 A requester with I_Req[i]=0 SHALL never be granted.
REQ-015 FSM states SHALL be IDLE, GRANT, REVOKE; reset state IDLE.
REQ-016 IDLE: if any I_Req bit is 1, the winner is registered into O_Grant/O_Owner at the next edge and state goes to GRANT; else stay IDLE.
REQ-017 Grant latency SHALL be exactly 1 cycle from first cycle a request is visible in IDLE to O_Grant asserted.
REQ-018 GRANT: grant holds while I_Req[O_Owner]=1; hold counter increments each GRANT cycle.
REQ-019 GRANT: owner dropping I_Req SHALL clear O_Grant at the next edge and return to IDLE (no re-arbitration in the same edge).
REQ-020 GRANT: hold counter reaching HOLD_MAX-1 with any other I_Req bit set SHALL clear O_Grant, pulse O_Revoke, enter REVOKE.
REQ-021 GRANT: hold counter at HOLD_MAX-1 with no other requester SHALL saturate and keep the grant.
REQ-022 Owner drop and timeout in the same cycle SHALL be treated as a normal drop (no O_Revoke).
REQ-023 REVOKE: one idle cycle with O_Grant=0, then IDLE; the revoked requester keeps requesting and competes normally.
REQ-024 Age[i] SHALL increment (saturating) each cycle I_Req[i]=1 and requester i is not granted; cleared on grant to i and whenever I_Req[i]=0.
REQ-025 Hold counter SHALL clear on every entry to GRANT.
REQ-026 O_Grant SHALL be one-hot or zero at all times; O_Busy = OR of O_Grant.

Reset
REQ-027 Reset assertion SHALL immediately (asynchronously) force: state IDLE, O_Grant=0, O_Owner=0, O_Busy=0, O_Revoke=0, all Age=0, hold counter=0.
REQ-028 Reset asserted mid-grant SHALL drop the grant without O_Revoke; first grant after deassertion follows REQ-016.

Verification
REQ-029 I_Req=0100, pri all 0 -> O_Grant=0100, O_Owner=2, O_Busy=1 one cycle later.
REQ-030 I_Req=1111, I_Pri={0:5,1:5,2:3,3:5}, ages 0 -> O_Grant=1000 (tie 1 vs 3 favours 3 side).
REQ-031 Requester 0 holds with requester 1 waiting, HOLD_MAX=16 -> grant to 0 for 16 cycles, O_Revoke pulse, one zero cycle, then O_Grant=0010 (aged).
REQ-032 Requester 0 sole requester 40 cycles -> grant never revoked, O_Revoke stays 0.
REQ-033 Owner 3 drops I_Req while requester 1 waits -> O_Grant=0000 next cycle, O_Grant=0010 the cycle after.
REQ-034 Reset pulse low during GRANT -> all outputs zero without clock edge; after release with I_Req=0001 -> O_Grant=0001 one cycle later.
